// File: rtl/mio_arbiter.sv
// Two-port round-robin arbiter that sequences one fixed-latency access at a time
// to a synchronous memory and returns registered read data plus a ready pulse per port.
module mio_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dev_req,
    input  logic              dev_we,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    output logic [DATA_W-1:0] dev_rdata,
    output logic              dev_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant_q;
    logic              last_dev;     // 1 = dev owned the previous access
    logic              first_q;      // marks the first BUSY cycle, where mem_en fires
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pick_cpu;
    logic              pick_dev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        pick_cpu  = 1'b0;
        pick_dev  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that did not own the last access wins.
                if (cpu_req && (!dev_req || last_dev)) begin
                    pick_cpu  = 1'b1;
                    state_nxt = BUSY;
                end else if (dev_req) begin
                    pick_dev  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY:    if (cnt == '0) state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            grant_q   <= 2'b00;
            last_dev  <= 1'b1;
            first_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rdata <= '0;
            dev_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_cpu || pick_dev) begin
                        grant_q  <= {pick_dev, pick_cpu};
                        last_dev <= pick_dev;
                        we_q     <= pick_cpu ? cpu_we    : dev_we;
                        addr_q   <= pick_cpu ? cpu_addr  : dev_addr;
                        wdata_q  <= pick_cpu ? cpu_wdata : dev_wdata;
                        cnt      <= CNT_W'(MEM_LAT - 1);
                        first_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    first_q <= 1'b0;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                CAPT: begin
                    if (!we_q) begin
                        if (grant_q[0])      cpu_rdata <= mem_rdata;
                        else if (grant_q[1]) dev_rdata <= mem_rdata;
                    end
                end
                RESP:    grant_q <= 2'b00;
                default: grant_q <= 2'b00;
            endcase
        end
    end

    // Bus outputs decode from state so reset forces them low without a clock.
    assign mem_en    = (state == BUSY) && first_q;
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = (state == BUSY) ? addr_q  : '0;
    assign mem_wdata = (state == BUSY) ? wdata_q : '0;
    assign grant     = grant_q;
    assign busy      = (state != IDLE);
    assign cpu_ready = (state == RESP) && grant_q[0];
    assign dev_ready = (state == RESP) && grant_q[1];

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Two-port arbiter and access sequencer for the shared memory/IO bus behind the multicycle CPU. It accepts access requests from the CPU control path (CPU_MIO/MIO_ready side) and from a secondary bus master (display/DMA device), grants one at a time with round-robin fairness, and sequences a single fixed-latency access to the synchronous memory. Each granted requester gets a registered read-data word and a one-cycle ready pulse.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles (≥1); rdata valid MEM_LAT cycles after the mem_en cycle
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req / dev_req  in  1  access request, held until that port's ready
- cpu_we / dev_we  in  1  1 = write, 0 = read
- cpu_addr / dev_addr  in  ADDR_W  access address
- cpu_wdata / dev_wdata  in  DATA_W  write data
- cpu_rdata / dev_rdata  out  DATA_W  registered read data, per port
- cpu_ready / dev_ready  out  1  one-cycle completion pulse (cpu_ready drives MIO_ready)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- grant  out  2  one-hot owner, bit0 = CPU, bit1 = dev; 00 when idle
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, BUSY, CAPT, RESP.
- IDLE: requests are sampled. If only one port requests, it wins. If both request, the port not in last_grant wins. On a win: grant, last_grant, we, addr and wdata are latched; next state is BUSY with the latency counter set to MEM_LAT-1.
- BUSY: mem_addr, mem_we and mem_wdata are held from the latched values for the whole state. mem_en is high only in the first BUSY cycle, and mem_we is gated by mem_en. The counter decrements; when it reaches 0, the next state is CAPT.
- CAPT: for a read, mem_rdata is captured into the granted port's rdata register at the end of the cycle. For a write, rdata is unchanged. Next state is RESP.
- RESP: the granted port's ready is high for exactly this cycle. grant clears at the end of the cycle and the next state is IDLE.
- The requester holds req and its signals stable until its ready. A req still high in the cycle after ready is a new request.
- Requests are not sampled in BUSY, CAPT or RESP; a losing requester waits.
- A req that drops mid-access does not abort the access. The access completes and ready still pulses.
- rdata holds its value until the next read completes on that port.
- Reset (async, any state): state goes to IDLE and every output goes to 0 immediately, including both rdata registers, grant, busy, ready and mem_*. last_grant is set to dev, so the CPU wins the first tie. An in-flight access is abandoned and produces no ready.

## Timing
- Request sampled in IDLE cycle T:
  - grant/busy high from T+1
  - mem_en high in T+1 only
  - BUSY spans T+1..T+MEM_LAT
  - CAPT at T+MEM_LAT+1
  - ready and valid rdata at T+MEM_LAT+2
  - IDLE at T+MEM_LAT+3
- Read and write accesses have identical latency: MEM_LAT+2 cycles from sampling to ready.
- Minimum issue interval is MEM_LAT+3 cycles, because one IDLE cycle always separates accesses.
- All outputs are registered or decoded from state only; there are no combinational paths from req to mem_*.

## Test plan
- **Reset:** assert reset mid-cycle → all outputs 0 asynchronously, with no clock edge needed. Release → busy=0, grant=00.
- **CPU read, MEM_LAT=2:** cpu_req=1, cpu_we=0, cpu_addr=0x10 sampled at T; memory model returns 0xDEADBEEF. Expect mem_en=1, mem_addr=0x10 at T+1 only; cpu_ready=1 at T+4 only; cpu_rdata=0xDEADBEEF from T+4.
- **Simultaneous requests after reset:** both req at T.
  - CPU is granted first: grant=01, cpu_ready at T+4.
  - dev is sampled at T+5: grant=10, dev_ready at T+9.
- **Both requests held continuously:** grant sequence is 01,10,01,10; each ready pulses once per access; no port is granted twice in a row.
- **dev write:** dev_req=1, dev_we=1, dev_addr=0x20, dev_wdata=0x000055AA. Expect mem_en=mem_we=1 for one cycle with that address and data; dev_ready at T+4; dev_rdata unchanged.
- **Reset during BUSY:** assert reset at T+2 of a CPU read → no ready pulse, outputs 0. After release, with both ports requesting, the CPU is granted first.
